// File: rtl/bayer_stream_gen_if.sv
// Capture-side pixel bus between the Bayer stream source and the image pipeline.
// oDVAL qualifies oDATA/oX_Cont/oY_Cont each cycle; there is no ready, so the consumer must take every valid beat.
interface bayer_stream_gen_if;
  logic        iSTART;
  logic        iCONT;
  logic        iSTOP;
  logic [1:0]  iPATTERN;
  logic [11:0] oDATA;
  logic        oDVAL;
  logic [10:0] oX_Cont;
  logic [10:0] oY_Cont;
  logic        oFVAL;
  logic        oFRAME_DONE;
  logic [15:0] oFRAME_CNT;
  logic [1:0]  dbgState;

  modport master (
    input  iSTART, iCONT, iSTOP, iPATTERN,
    output oDATA, oDVAL, oX_Cont, oY_Cont, oFVAL, oFRAME_DONE, oFRAME_CNT, dbgState
  );

  modport slave (
    output iSTART, iCONT, iSTOP, iPATTERN,
    input  oDATA, oDVAL, oX_Cont, oY_Cont, oFVAL, oFRAME_DONE, oFRAME_CNT, dbgState
  );
endinterface

// File: rtl/bayer_stream_gen.sv
// Raw GRBG Bayer frame source with line/frame blanking and four test patterns.
// Every output is a flop whose D input is derived from the next-state values.
module bayer_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 4
) (
  input  logic iCLK,
  input  logic iRST,
  bayer_stream_gen_if.master bus
);
  localparam int VB_CYCLES = V_BLANK * (H_ACTIVE + H_BLANK);
  localparam int VB_W = (VB_CYCLES > 1) ? $clog2(VB_CYCLES) : 1;
  localparam int HB_W = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
  localparam logic [10:0]     X_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [10:0]     Y_LAST  = 11'(V_ACTIVE - 1);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(H_BLANK - 1);
  localparam logic [VB_W-1:0] VB_LAST = VB_W'(VB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } state_t;

  state_t          state, stateNxt;
  logic [10:0]     x, xNxt;
  logic [10:0]     y, yNxt;
  logic [HB_W-1:0] hCnt, hCntNxt;
  logic [VB_W-1:0] vCnt, vCntNxt;
  logic [1:0]      pattern, patternNxt;
  logic            stopFlag, stopFlagNxt;

  logic [11:0]     dataD;
  logic            dvalD;
  logic            fvalD;
  logic            doneD;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state           <= IDLE;
      x               <= '0;
      y               <= '0;
      hCnt            <= '0;
      vCnt            <= '0;
      pattern         <= '0;
      stopFlag        <= 1'b0;
      bus.oDATA       <= '0;
      bus.oDVAL       <= 1'b0;
      bus.oFVAL       <= 1'b0;
      bus.oFRAME_DONE <= 1'b0;
      bus.oFRAME_CNT  <= '0;
    end else begin
      state           <= stateNxt;
      x               <= xNxt;
      y               <= yNxt;
      hCnt            <= hCntNxt;
      vCnt            <= vCntNxt;
      pattern         <= patternNxt;
      stopFlag        <= stopFlagNxt;
      bus.oDATA       <= dataD;
      bus.oDVAL       <= dvalD;
      bus.oFVAL       <= fvalD;
      bus.oFRAME_DONE <= doneD;
      if (doneD) begin
        bus.oFRAME_CNT <= bus.oFRAME_CNT + 16'd1;
      end
    end
  end

  always_comb begin
    stateNxt    = state;
    xNxt        = x;
    yNxt        = y;
    hCntNxt     = hCnt;
    vCntNxt     = vCnt;
    patternNxt  = pattern;
    stopFlagNxt = stopFlag | bus.iSTOP;
    unique case (state)
      IDLE: begin
        // A stop alone is meaningless here; with a start it limits the run to one frame.
        stopFlagNxt = 1'b0;
        if (bus.iSTART) begin
          stateNxt    = ACTIVE;
          xNxt        = '0;
          yNxt        = '0;
          patternNxt  = bus.iPATTERN;
          stopFlagNxt = bus.iSTOP;
        end
      end
      ACTIVE: begin
        if (x == X_LAST) begin
          stateNxt = HBLANK;
          hCntNxt  = '0;
        end else begin
          xNxt = x + 11'd1;
        end
      end
      HBLANK: begin
        if (hCnt == HB_LAST) begin
          if (y != Y_LAST) begin
            stateNxt = ACTIVE;
            xNxt     = '0;
            yNxt     = y + 11'd1;
          end else begin
            stateNxt = VBLANK;
            vCntNxt  = '0;
          end
        end else begin
          hCntNxt = hCnt + HB_W'(1);
        end
      end
      VBLANK: begin
        if (vCnt == VB_LAST) begin
          if (bus.iCONT && !(stopFlag || bus.iSTOP)) begin
            stateNxt   = ACTIVE;
            xNxt       = '0;
            yNxt       = '0;
            patternNxt = bus.iPATTERN;
          end else begin
            stateNxt    = IDLE;
            stopFlagNxt = 1'b0;
          end
        end else begin
          vCntNxt = vCnt + VB_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    dvalD = (stateNxt == ACTIVE);
    fvalD = (stateNxt == ACTIVE) || (stateNxt == HBLANK);
    doneD = (stateNxt == VBLANK) && (vCntNxt == VB_LAST);
    dataD = '0;
    if (dvalD) begin
      case (patternNxt)
        2'd0: begin
          // GRBG phase: even row G/R, odd row B/G.
          case ({yNxt[0], xNxt[0]})
            2'b01:   dataD = 12'hFFF;
            2'b10:   dataD = 12'h000;
            default: dataD = 12'h800;
          endcase
        end
        2'd1:    dataD = {xNxt[10:0], 1'b0};
        2'd2:    dataD = {yNxt[8:0], 3'b000};
        default: dataD = (xNxt[3] ^ yNxt[3]) ? 12'hFFF : 12'h000;
      endcase
    end
  end

  assign bus.oX_Cont  = x;
  assign bus.oY_Cont  = y;
  assign bus.dbgState = state;
endmodule

// File: tb/tb_bayer_stream_gen.sv
// Bench for bayer_stream_gen: three geometries, cycle tables for the reference frame,
// and a pixel scoreboard fed at every frame start.
module tb_bayer_stream_gen;
  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  always #5 iCLK = ~iCLK;

  bayer_stream_gen_if busA();
  bayer_stream_gen_if busB();
  bayer_stream_gen_if busC();

  bayer_stream_gen #(.H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(2), .V_BLANK(1))
    dutA (.iCLK(iCLK), .iRST(iRST), .bus(busA.master));
  bayer_stream_gen #(.H_ACTIVE(8), .V_ACTIVE(2), .H_BLANK(2), .V_BLANK(1))
    dutB (.iCLK(iCLK), .iRST(iRST), .bus(busB.master));
  bayer_stream_gen #(.H_ACTIVE(16), .V_ACTIVE(16), .H_BLANK(2), .V_BLANK(1))
    dutC (.iCLK(iCLK), .iRST(iRST), .bus(busC.master));

  int testsRun = 0;
  int testsFailed = 0;

  // Entry layout: {dut id[1:0], y[10:0], x[10:0], data[11:0]}
  logic [35:0] exp_q[$];

  typedef struct {
    logic        dval;
    logic        fval;
    logic        done;
    logic        chkXY;
    logic [10:0] x;
    logic [10:0] y;
    logic [11:0] data;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs[19];

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic [11:0] expPix(input logic [1:0] pat, input int x, input int y);
    case (pat)
      2'd0: begin
        if (y % 2 == 0) return (x % 2 == 0) ? 12'h800 : 12'hFFF;
        else            return (x % 2 == 0) ? 12'h000 : 12'h800;
      end
      2'd1:    return 12'((2 * x) % 4096);
      2'd2:    return 12'((8 * y) % 4096);
      default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  task automatic pushFrame(input int id, input logic [1:0] pat, input int h, input int v);
    for (int yy = 0; yy < v; yy++)
      for (int xx = 0; xx < h; xx++)
        exp_q.push_back({2'(id), 11'(yy), 11'(xx), expPix(pat, xx, yy)});
  endtask

  task automatic scorePixel(input int id, input logic dval, input logic [10:0] x,
                            input logic [10:0] y, input logic [11:0] d);
    logic [35:0] e;
    if (dval) begin
      if (exp_q.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("FAIL pixel_unexpected: dut %0d emitted x=%0d y=%0d data=%h, expected no pixel",
                 id, x, y, d);
      end else begin
        e = exp_q.pop_front();
        check("pixel", {2'(id), y, x, d}, e);
      end
    end
  endtask

  always @(negedge iCLK) begin
    scorePixel(0, busA.oDVAL, busA.oX_Cont, busA.oY_Cont, busA.oDATA);
    scorePixel(1, busB.oDVAL, busB.oX_Cont, busB.oY_Cont, busB.oDATA);
    scorePixel(2, busC.oDVAL, busC.oX_Cont, busC.oY_Cont, busC.oDATA);
  end

  function automatic logic doneOf(input int id);
    case (id)
      0:       return busA.oFRAME_DONE;
      1:       return busB.oFRAME_DONE;
      default: return busC.oFRAME_DONE;
    endcase
  endfunction

  // Ticks until the chosen DUT pulses oFRAME_DONE; reports the number of ticks taken.
  task automatic waitDone(input int id, input int budget, input string name, output int n);
    n = 0;
    while (doneOf(id) !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    testsRun++;
    if (n >= budget) begin
      testsFailed++;
      $display("FAIL %s: no frame-done within %0d cycles, expected one", name, budget);
    end
  endtask

  task automatic doReset();
    iRST = 1'b1;
    tick();
    tick();
    iRST = 1'b0;
  endtask

  task automatic setVec(input int c, input logic dval, input logic fval, input logic done,
                        input logic chkXY, input int x, input int y, input logic [11:0] data,
                        input int cnt);
    vecs[c-1].dval  = dval;
    vecs[c-1].fval  = fval;
    vecs[c-1].done  = done;
    vecs[c-1].chkXY = chkXY;
    vecs[c-1].x     = 11'(x);
    vecs[c-1].y     = 11'(y);
    vecs[c-1].data  = data;
    vecs[c-1].cnt   = 16'(cnt);
  endtask

  task automatic checkIdleA(input string name, input logic [15:0] cnt);
    check({name, "_dval"}, busA.oDVAL, 1'b0);
    check({name, "_fval"}, busA.oFVAL, 1'b0);
    check({name, "_cnt"}, busA.oFRAME_CNT, cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int fvalCycles;
    int dvalOutside;
    logic [11:0] row0 [4];
    logic [11:0] row1 [4];

    busA.iSTART = 0; busA.iCONT = 0; busA.iSTOP = 0; busA.iPATTERN = 0;
    busB.iSTART = 0; busB.iCONT = 0; busB.iSTOP = 0; busB.iPATTERN = 0;
    busC.iSTART = 0; busC.iCONT = 0; busC.iSTOP = 0; busC.iPATTERN = 0;

    row0 = '{12'h800, 12'hFFF, 12'h800, 12'hFFF};
    row1 = '{12'h000, 12'h800, 12'h000, 12'h800};
    for (int i = 0; i < 4; i++) begin
      setVec(1 + i, 1, 1, 0, 1, i, 0, row0[i], 0);
      setVec(7 + i, 1, 1, 0, 1, i, 1, row1[i], 0);
    end
    setVec(5, 0, 1, 0, 1, 3, 0, 12'h000, 0);
    setVec(6, 0, 1, 0, 1, 3, 0, 12'h000, 0);
    setVec(11, 0, 1, 0, 1, 3, 1, 12'h000, 0);
    setVec(12, 0, 1, 0, 1, 3, 1, 12'h000, 0);
    for (int c = 13; c <= 17; c++) setVec(c, 0, 0, 0, 0, 0, 0, 12'h000, 0);
    setVec(18, 0, 0, 1, 0, 0, 0, 12'h000, 1);
    setVec(19, 0, 0, 0, 0, 0, 0, 12'h000, 1);

    // Reset state
    doReset();
    check("rst_dval", busA.oDVAL, 1'b0);
    check("rst_fval", busA.oFVAL, 1'b0);
    check("rst_done", busA.oFRAME_DONE, 1'b0);
    check("rst_data", busA.oDATA, 12'h000);
    check("rst_xy", {busA.oX_Cont, busA.oY_Cont}, 22'd0);
    check("rst_cnt", busA.oFRAME_CNT, 16'd0);
    check("rst_state", busA.dbgState, 2'd0);

    // Reference frame, flat Bayer, cycle-exact table
    busA.iPATTERN = 2'd0;
    busA.iSTART = 1'b1;
    pushFrame(0, 2'd0, 4, 2);
    tick();
    busA.iSTART = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      check($sformatf("t1_dval_c%0d", c), busA.oDVAL, vecs[c-1].dval);
      check($sformatf("t1_fval_c%0d", c), busA.oFVAL, vecs[c-1].fval);
      check($sformatf("t1_done_c%0d", c), busA.oFRAME_DONE, vecs[c-1].done);
      check($sformatf("t1_data_c%0d", c), busA.oDATA, vecs[c-1].data);
      check($sformatf("t1_cnt_c%0d", c), busA.oFRAME_CNT, vecs[c-1].cnt);
      if (vecs[c-1].chkXY) begin
        check($sformatf("t1_xy_c%0d", c), {busA.oX_Cont, busA.oY_Cont}, {vecs[c-1].x, vecs[c-1].y});
      end
      tick();
    end

    // Horizontal ramp; pattern change mid-frame must not take effect
    busB.iPATTERN = 2'd1;
    busB.iSTART = 1'b1;
    pushFrame(1, 2'd1, 8, 2);
    tick();
    busB.iSTART = 1'b0;
    tick();
    tick();
    busB.iPATTERN = 2'd3;
    waitDone(1, 60, "t2_wait_done", n);
    check("t2_done_cycle", 3 + n, 30);
    check("t2_cnt", busB.oFRAME_CNT, 16'd1);
    busB.iPATTERN = 2'd0;
    repeat (5) tick();
    check("t2_idle_dval", busB.oDVAL, 1'b0);

    // Free-running frames, stop during frame 2 line 0
    doReset();
    check("t3_cnt_rst", busA.oFRAME_CNT, 16'd0);
    busA.iCONT = 1'b1;
    busA.iPATTERN = 2'd0;
    busA.iSTART = 1'b1;
    pushFrame(0, 2'd0, 4, 2);
    pushFrame(0, 2'd2, 4, 2);
    tick();
    busA.iSTART = 1'b0;
    busA.iPATTERN = 2'd2;
    waitDone(0, 40, "t3_wait_done1", n);
    check("t3_done1_cycle", 1 + n, 18);
    check("t3_cnt1", busA.oFRAME_CNT, 16'd1);
    tick();
    check("t3_f2_dval", busA.oDVAL, 1'b1);
    check("t3_f2_xy", {busA.oX_Cont, busA.oY_Cont}, 22'd0);
    check("t3_f2_fval", busA.oFVAL, 1'b1);
    busA.iSTOP = 1'b1;
    tick();
    busA.iSTOP = 1'b0;
    waitDone(0, 40, "t3_wait_done2", n);
    check("t3_done2_cycle", 20 + n, 36);
    check("t3_cnt2", busA.oFRAME_CNT, 16'd2);
    tick();
    checkIdleA("t3_after_stop", 16'd2);
    repeat (10) tick();
    checkIdleA("t3_stays_idle", 16'd2);
    busA.iCONT = 1'b0;

    // Reset in the middle of row 1
    busA.iPATTERN = 2'd0;
    busA.iSTART = 1'b1;
    pushFrame(0, 2'd0, 4, 2);
    tick();
    busA.iSTART = 1'b0;
    repeat (7) tick();
    check("t4_mid_row1", {busA.oDVAL, busA.oY_Cont}, {1'b1, 11'd1});
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    check("t4_rst_dval", busA.oDVAL, 1'b0);
    check("t4_rst_fval", busA.oFVAL, 1'b0);
    check("t4_rst_done", busA.oFRAME_DONE, 1'b0);
    check("t4_rst_data", busA.oDATA, 12'h000);
    check("t4_rst_xy", {busA.oX_Cont, busA.oY_Cont}, 22'd0);
    check("t4_rst_cnt", busA.oFRAME_CNT, 16'd0);
    check("t4_rst_state", busA.dbgState, 2'd0);
    check("t4_pixels_left", exp_q.size(), 2);
    exp_q.delete();
    busA.iSTART = 1'b1;
    pushFrame(0, 2'd0, 4, 2);
    tick();
    busA.iSTART = 1'b0;
    check("t4_restart", {busA.oDVAL, busA.oX_Cont, busA.oY_Cont, busA.oDATA},
          {1'b1, 11'd0, 11'd0, 12'h800});
    waitDone(0, 40, "t4_wait_done", n);
    check("t4_cnt", busA.oFRAME_CNT, 16'd1);
    tick();

    // iSTART held across a whole frame and into the following idle cycle
    doReset();
    busA.iSTART = 1'b1;
    pushFrame(0, 2'd0, 4, 2);
    pushFrame(0, 2'd0, 4, 2);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c + 1 == 18) check("t5_done_c18", {busA.oFRAME_DONE, busA.oFRAME_CNT}, {1'b1, 16'd1});
      if (c + 1 == 19) check("t5_gap_c19", {busA.oDVAL, busA.oFVAL}, 2'b00);
    end
    busA.iSTART = 1'b0;
    check("t5_second_start", {busA.oDVAL, busA.oX_Cont, busA.oY_Cont}, {1'b1, 22'd0});
    waitDone(0, 40, "t5_wait_done", n);
    check("t5_done2_cycle", 20 + n, 37);
    check("t5_cnt", busA.oFRAME_CNT, 16'd2);
    repeat (5) tick();
    checkIdleA("t5_idle", 16'd2);

    // Checkerboard on 16x16 with frame-valid coverage
    busC.iPATTERN = 2'd3;
    busC.iSTART = 1'b1;
    pushFrame(2, 2'd3, 16, 16);
    tick();
    busC.iSTART = 1'b0;
    fvalCycles = 0;
    dvalOutside = 0;
    for (int c = 1; c <= 306; c++) begin
      if (busC.oFVAL) fvalCycles++;
      if (busC.oDVAL && !busC.oFVAL) dvalOutside++;
      if (c == 8)   check("t6_x7y0", {busC.oX_Cont, busC.oY_Cont, busC.oDATA}, {11'd7, 11'd0, 12'h000});
      if (c == 9)   check("t6_x8y0", {busC.oX_Cont, busC.oY_Cont, busC.oDATA}, {11'd8, 11'd0, 12'hFFF});
      if (c == 153) check("t6_x8y8", {busC.oX_Cont, busC.oY_Cont, busC.oDATA}, {11'd8, 11'd8, 12'h000});
      if (c == 288) check("t6_fval_last_hblank", busC.oFVAL, 1'b1);
      if (c == 289) check("t6_fval_vblank", busC.oFVAL, 1'b0);
      if (c == 306) check("t6_done_c306", busC.oFRAME_DONE, 1'b1);
      tick();
    end
    check("t6_fval_cycles", fvalCycles, 288);
    check("t6_dval_outside_fval", dvalOutside, 0);
    check("t6_cnt", busC.oFRAME_CNT, 16'd1);

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
